// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice: queue entry
// layout, datapath width and the default boot address.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetch entries. Entries are allocated at grant,
// filled in grant order as responses return, and popped in order once filled.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_instr,
  input  logic            pop_en,
  output logic [PW-1:0]   allocated,
  output logic [PW-1:0]   unreturned,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);

  localparam int IW = $clog2(QDEPTH);

  fetch_entry_t entries [QDEPTH];
  fetch_entry_t head;
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] pop_ptr;
  logic          do_fill;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign allocated  = alloc_ptr - pop_ptr;
  assign unreturned = alloc_ptr - fill_ptr;
  assign head       = entries[pop_ptr[IW-1:0]];
  assign head_valid = (allocated != '0) && head.filled;
  assign head_pc    = head_valid ? head.pc    : '0;
  assign head_instr = head_valid ? head.instr : '0;

  assign do_fill = fill_en && (unreturned != '0);
  assign do_pop  = pop_en && head_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < QDEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      // Stale filled flags are harmless: allocation clears them on reuse.
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
    end else begin
      if (alloc_en) begin
        entries[alloc_ptr[IW-1:0]].pc     <= alloc_pc;
        entries[alloc_ptr[IW-1:0]].instr  <= '0;
        entries[alloc_ptr[IW-1:0]].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (do_fill) begin
        entries[fill_ptr[IW-1:0]].instr  <= fill_instr;
        entries[fill_ptr[IW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (do_pop) begin
        pop_ptr <= pop_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, issues in-order word requests,
// queues returned words with their PCs and hands them to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);

  localparam int PW = $clog2(QDEPTH) + 1;

  // Handshakes: a request transfers when imem_req && imem_gnt; responses
  // return in grant order on imem_rvalid; decode takes the head on
  // id_valid && id_ready. A redirect withdraws any ungranted request.
  logic [XLEN-1:0] pc;
  logic [PW-1:0]   drop_cnt;
  logic [PW-1:0]   allocated;
  logic [PW-1:0]   unreturned;
  logic            grant;
  logic            drop_resp;
  logic            fill_en;
  logic            pop_en;

  assign imem_req  = rst_n && !redirect_valid && (allocated < PW'(QDEPTH));
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign drop_resp = imem_rvalid && (drop_cnt != '0);
  assign fill_en   = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign pop_en    = id_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Every response still owed to the old stream must be swallowed,
      // minus the one arriving right now.
      pc       <= redirect_pc;
      drop_cnt <= drop_cnt + unreturned - PW'(imem_rvalid);
    end else begin
      if (grant) pc <= pc_next(pc);
      if (drop_resp) drop_cnt <= drop_cnt - PW'(1);
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc_en   (grant),
    .alloc_pc   (pc),
    .fill_en    (fill_en),
    .fill_instr (imem_rdata),
    .pop_en     (pop_en),
    .allocated  (allocated),
    .unreturned (unreturned),
    .head_valid (id_valid),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

endmodule
